// File: rtl/data_cache_pkg.sv
// Shared types and constants for the data cache and the load/store decoder.
package data_cache_pkg;

  localparam int unsigned ADDR_BITS      = 32;
  localparam int unsigned WORD_BITS      = 32;
  localparam int unsigned BLOCK_BYTES    = 16;
  localparam int unsigned BLOCK_BITS     = BLOCK_BYTES * 8;
  localparam int unsigned OFFSET_BITS    = $clog2(BLOCK_BYTES);
  localparam int unsigned MAIN_ADDR_BITS = ADDR_BITS - OFFSET_BITS;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITEBACK,
    ST_FETCH,
    ST_UPDATE
  } state_t;

  // RV32I load widths
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // RV32I store widths
  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;

  // Registered main-memory request payload
  typedef struct packed {
    logic                      read;
    logic                      write;
    logic [MAIN_ADDR_BITS-1:0] addr;
    logic [BLOCK_BITS-1:0]     data;
  } main_req_t;

endpackage

// File: rtl/data_cache_if.sv
// Pipeline-side and main-memory-side bundles of the data cache.
interface data_cache_if;
  import data_cache_pkg::*;

  logic                 mem_read;
  logic                 mem_write;
  logic [2:0]           funct3;
  logic [ADDR_BITS-1:0] address;
  logic [WORD_BITS-1:0] write_data;
  logic [WORD_BITS-1:0] read_data;
  logic                 busywait;

  modport master (output mem_read, mem_write, funct3, address, write_data,
                  input  read_data, busywait);
  modport slave  (input  mem_read, mem_write, funct3, address, write_data,
                  output read_data, busywait);
endinterface

interface data_cache_mem_if;
  import data_cache_pkg::*;

  logic                      main_read;
  logic                      main_write;
  logic [MAIN_ADDR_BITS-1:0] main_address;
  logic [BLOCK_BITS-1:0]     main_writedata;
  logic [BLOCK_BITS-1:0]     main_readdata;
  logic                      main_busywait;

  modport master (output main_read, main_write, main_address, main_writedata,
                  input  main_readdata, main_busywait);
  modport slave  (input  main_read, main_write, main_address, main_writedata,
                  output main_readdata, main_busywait);
endinterface

// File: rtl/data_cache_load_store_align.sv
// Byte/half/word extraction with extension for loads; lane mask and replicated data for stores.
module data_cache_load_store_align
  import data_cache_pkg::*;
(
  input  logic [2:0]             funct3,
  input  logic [OFFSET_BITS-1:0] offset,
  input  logic [BLOCK_BITS-1:0]  block,
  input  logic [WORD_BITS-1:0]   store_data,
  output logic [WORD_BITS-1:0]   load_data,
  output logic [BLOCK_BYTES-1:0] byte_mask,
  output logic [BLOCK_BITS-1:0]  store_block
);

  logic [WORD_BITS-1:0] word_sel;
  logic [7:0]           byte_sel;
  logic [15:0]          half_sel;

  // Select the addressed word, then byte/half within it; low address bits ignored per width
  always_comb begin
    word_sel = block[{offset[3:2], 5'b00000} +: 32];
    byte_sel = word_sel[{offset[1:0], 3'b000} +: 8];
    half_sel = word_sel[{offset[1], 4'b0000} +: 16];
    case (funct3)
      F3_LB:   load_data = {{24{byte_sel[7]}}, byte_sel};
      F3_LH:   load_data = {{16{half_sel[15]}}, half_sel};
      F3_LBU:  load_data = {24'h000000, byte_sel};
      F3_LHU:  load_data = {16'h0000, half_sel};
      default: load_data = word_sel;
    endcase
  end

  // Store data is replicated across all lanes; the mask picks the lanes that get written
  always_comb begin
    case (funct3)
      F3_SB: begin
        byte_mask   = 16'(16'h0001 << offset);
        store_block = {16{store_data[7:0]}};
      end
      F3_SH: begin
        byte_mask   = 16'(16'h0003 << {offset[3:1], 1'b0});
        store_block = {8{store_data[15:0]}};
      end
      default: begin
        byte_mask   = 16'(16'h000F << {offset[3:2], 2'b00});
        store_block = {4{store_data}};
      end
    endcase
  end

endmodule

// File: rtl/data_cache.sv
// Direct-mapped, write-back, write-allocate data cache for the MEM stage.
module data_cache
  import data_cache_pkg::*;
#(
  parameter int unsigned NUM_LINES = 8
) (
  input  logic              clk,
  input  logic              reset,
  data_cache_if.slave       cpu,
  data_cache_mem_if.master  mem
);

  localparam int unsigned IDX_BITS = $clog2(NUM_LINES);
  localparam int unsigned TAG_BITS = ADDR_BITS - OFFSET_BITS - IDX_BITS;

  logic [BLOCK_BITS-1:0] data_q [NUM_LINES];
  logic [TAG_BITS-1:0]   tag_q  [NUM_LINES];
  logic [NUM_LINES-1:0]  valid_q;
  logic [NUM_LINES-1:0]  dirty_q;

  state_t    state_q, state_d;
  main_req_t req_q, req_d;

  logic [IDX_BITS-1:0]    idx;
  logic [TAG_BITS-1:0]    tag;
  logic [OFFSET_BITS-1:0] offset;
  logic                   request;
  logic                   is_load;
  logic                   hit;

  logic [WORD_BITS-1:0]   load_data;
  logic [BLOCK_BYTES-1:0] byte_mask;
  logic [BLOCK_BITS-1:0]  store_block;
  logic [BLOCK_BITS-1:0]  merged_block;

  assign idx     = cpu.address[OFFSET_BITS +: IDX_BITS];
  assign tag     = cpu.address[ADDR_BITS-1 -: TAG_BITS];
  assign offset  = cpu.address[OFFSET_BITS-1:0];
  assign request = cpu.mem_read | cpu.mem_write;
  assign is_load = cpu.mem_read & ~cpu.mem_write;
  assign hit     = valid_q[idx] && (tag_q[idx] == tag);

  data_cache_load_store_align u_align (
    .funct3      (cpu.funct3),
    .offset      (offset),
    .block       (data_q[idx]),
    .store_data  (cpu.write_data),
    .load_data   (load_data),
    .byte_mask   (byte_mask),
    .store_block (store_block)
  );

  // Byte-lane merge of store data into the resident block
  always_comb begin
    merged_block = data_q[idx];
    for (int i = 0; i < int'(BLOCK_BYTES); i++) begin
      if (byte_mask[i]) merged_block[8*i +: 8] = store_block[8*i +: 8];
    end
  end

  // Stall and load data are combinational so hits cost no cycle
  assign cpu.busywait  = !reset && request && ((state_q != ST_IDLE) || !hit);
  assign cpu.read_data = (!reset && is_load && hit && (state_q == ST_IDLE)) ? load_data : '0;

  assign mem.main_read      = req_q.read;
  assign mem.main_write     = req_q.write;
  assign mem.main_address   = req_q.addr;
  assign mem.main_writedata = req_q.data;

  // Miss-handling FSM: next state and next registered main-memory request
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    case (state_q)
      ST_IDLE: begin
        if (request && !hit) begin
          if (valid_q[idx] && dirty_q[idx]) begin
            state_d     = ST_WRITEBACK;
            req_d.read  = 1'b0;
            req_d.write = 1'b1;
            req_d.addr  = MAIN_ADDR_BITS'({tag_q[idx], idx});
            req_d.data  = data_q[idx];
          end else begin
            state_d     = ST_FETCH;
            req_d.read  = 1'b1;
            req_d.write = 1'b0;
            req_d.addr  = MAIN_ADDR_BITS'({tag, idx});
          end
        end
      end
      ST_WRITEBACK: begin
        if (!mem.main_busywait) begin
          state_d     = ST_FETCH;
          req_d.read  = 1'b1;
          req_d.write = 1'b0;
          req_d.addr  = MAIN_ADDR_BITS'({tag, idx});
        end
      end
      ST_FETCH: begin
        if (!mem.main_busywait) begin
          state_d    = ST_UPDATE;
          req_d.read = 1'b0;
        end
      end
      ST_UPDATE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        req_d   = '0;
      end
    endcase
  end

  // State and main-request registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      req_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
    end
  end

  // Line status bits: filled lines become valid and clean, store hits mark dirty
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (state_q == ST_UPDATE) begin
      valid_q[idx] <= 1'b1;
      dirty_q[idx] <= 1'b0;
    end else if ((state_q == ST_IDLE) && cpu.mem_write && hit) begin
      dirty_q[idx] <= 1'b1;
    end
  end

  // Block data and tags: refill from main memory or merge a store hit
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state_q == ST_UPDATE) begin
        data_q[idx] <= mem.main_readdata;
        tag_q[idx]  <= tag;
      end else if ((state_q == ST_IDLE) && cpu.mem_write && hit) begin
        data_q[idx] <= merged_block;
      end
    end
  end

endmodule
